// File: rtl/wave_sel_ctrl.sv
// Waveform selector front panel: two debounced keys, per-channel pending selection,
// committed on DDS phase wrap or after a timeout.

module wave_sel_ctrl_deb #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_press
);
    // state  | meaning
    // IDLE   | key released and stable
    // DEB_DN | key seen low, waiting for a stable press
    // HELD   | press accepted, key still down
    // DEB_UP | key seen high, waiting for a stable release
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DEB_DN, HELD, DEB_UP} deb_state_t;

    deb_state_t    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_sync1, r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_press     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!r_sync2) begin
                    w_state_nxt = DEB_DN;
                    w_cnt_nxt   = '0;
                end
            end
            DEB_DN: begin
                if (r_sync2) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    o_press     = 1'b1;
                    w_state_nxt = HELD;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (r_sync2) begin
                    w_state_nxt = DEB_UP;
                    w_cnt_nxt   = '0;
                end
            end
            DEB_UP: begin
                if (!r_sync2) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule

module wave_sel_ctrl_ch #(
    parameter int TIMEOUT   = 1000000,
    parameter int NUM_WAVES = 3,
    parameter int SEL_INIT  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_next,
    input  logic       i_wrap,
    output logic [2:0] o_sel,
    output logic       o_pend,
    output logic       o_chg
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [2:0]    WAVE_LAST = 3'(NUM_WAVES - 1);

    logic [2:0]    r_sel, r_pend_sel;
    logic          r_pend, r_chg;
    logic [TW-1:0] r_tmo;
    logic          w_commit;
    logic [2:0]    w_base, w_inc;

    assign w_commit = r_pend & (i_wrap | (r_tmo == TMO_LAST));
    // A press stacks on the pending value even when that value commits this cycle.
    assign w_base   = r_pend ? r_pend_sel : r_sel;
    assign w_inc    = (w_base == WAVE_LAST) ? 3'd0 : w_base + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel      <= 3'(SEL_INIT);
            r_pend_sel <= '0;
            r_pend     <= 1'b0;
            r_chg      <= 1'b0;
            r_tmo      <= '0;
        end else begin
            r_chg <= w_commit;
            if (w_commit) r_sel <= r_pend_sel;
            if (i_next) begin
                r_pend_sel <= w_inc;
                r_pend     <= 1'b1;
                r_tmo      <= '0;
            end else if (w_commit) begin
                r_pend <= 1'b0;
                r_tmo  <= '0;
            end else if (r_pend) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    assign o_sel  = r_sel;
    assign o_pend = r_pend;
    assign o_chg  = r_chg;
endmodule

module wave_sel_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int TIMEOUT    = 1000000,
    parameter int NUM_WAVES  = 3,
    parameter int SEL_A_INIT = 0,
    parameter int SEL_B_INIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_key_next_n,
    input  logic       i_key_ch_n,
    input  logic       i_phase_wrap_a,
    input  logic       i_phase_wrap_b,
    output logic [2:0] o_sel_a,
    output logic [2:0] o_sel_b,
    output logic       o_edit_ch,
    output logic       o_pend_a,
    output logic       o_pend_b,
    output logic       o_chg_a,
    output logic       o_chg_b
);
    logic w_press_next, w_press_ch;
    logic r_edit_ch;

    wave_sel_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .clk(clk), .rst_n(rst_n), .i_key_n(i_key_next_n), .o_press(w_press_next)
    );

    wave_sel_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ch (
        .clk(clk), .rst_n(rst_n), .i_key_n(i_key_ch_n), .o_press(w_press_ch)
    );

    // NEXT is routed by the edit channel before any same-cycle CH toggle lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_edit_ch <= 1'b0;
        else if (w_press_ch) r_edit_ch <= ~r_edit_ch;
    end

    wave_sel_ctrl_ch #(.TIMEOUT(TIMEOUT), .NUM_WAVES(NUM_WAVES), .SEL_INIT(SEL_A_INIT)) u_ch_a (
        .clk(clk), .rst_n(rst_n), .i_next(w_press_next & ~r_edit_ch), .i_wrap(i_phase_wrap_a),
        .o_sel(o_sel_a), .o_pend(o_pend_a), .o_chg(o_chg_a)
    );

    wave_sel_ctrl_ch #(.TIMEOUT(TIMEOUT), .NUM_WAVES(NUM_WAVES), .SEL_INIT(SEL_B_INIT)) u_ch_b (
        .clk(clk), .rst_n(rst_n), .i_next(w_press_next & r_edit_ch), .i_wrap(i_phase_wrap_b),
        .o_sel(o_sel_b), .o_pend(o_pend_b), .o_chg(o_chg_b)
    );

    assign o_edit_ch = r_edit_ch;
endmodule

// File: tb/tb_wave_sel_ctrl.sv
// Bench for wave_sel_ctrl: directed panel scenarios, then random keys and wraps,
// with commits scoreboarded against a run-length/modular-arithmetic reference.

module tb_wave_sel_ctrl;
    localparam int DEB = 4;
    localparam int TMO = 32;
    localparam int NW  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_next_n = 1'b1, key_ch_n = 1'b1, wrap_a = 1'b0, wrap_b = 1'b0;
    logic [2:0] sel_a, sel_b;
    logic       edit_ch, pend_a, pend_b, chg_a, chg_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wave_sel_ctrl #(
        .DEB_CYCLES(DEB), .TIMEOUT(TMO), .NUM_WAVES(NW), .SEL_A_INIT(0), .SEL_B_INIT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_key_next_n(key_next_n), .i_key_ch_n(key_ch_n),
        .i_phase_wrap_a(wrap_a), .i_phase_wrap_b(wrap_b),
        .o_sel_a(sel_a), .o_sel_b(sel_b), .o_edit_ch(edit_ch),
        .o_pend_a(pend_a), .o_pend_b(pend_b), .o_chg_a(chg_a), .o_chg_b(chg_b)
    );

    typedef struct {int val; int cyc;} exp_t;
    exp_t q_a[$];
    exp_t q_b[$];

    // Reference: a key is accepted after DEB+1 consecutive synchronised samples at the new level.
    int m_cyc = 0;
    int m_sel[2], m_tgt[2], m_age[2], m_run[2];
    bit m_pend[2], m_s1[2], m_s2[2], m_acc[2];
    bit m_edit;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sel[0] = 0; m_sel[1] = 1;
        for (int k = 0; k < 2; k++) begin
            m_tgt[k] = 0; m_age[k] = 0; m_pend[k] = 0;
            m_s1[k] = 1; m_s2[k] = 1; m_acc[k] = 1; m_run[k] = 0;
        end
        m_edit = 0;
        q_a.delete();
        q_b.delete();
    endtask

    task automatic model_step();
        bit   press[2], raw[2], wr[2];
        bit   commit, nxt;
        int   base;
        exp_t e;
        m_cyc++;
        raw[0] = key_next_n; raw[1] = key_ch_n;
        wr[0]  = wrap_a;     wr[1]  = wrap_b;
        for (int k = 0; k < 2; k++) begin
            press[k] = 0;
            if (m_s2[k] != m_acc[k]) begin
                m_run[k]++;
                if (m_run[k] == DEB + 1) begin
                    m_acc[k] = m_s2[k];
                    m_run[k] = 0;
                    press[k] = !m_s2[k];
                end
            end else begin
                m_run[k] = 0;
            end
            m_s2[k] = m_s1[k];
            m_s1[k] = raw[k];
        end
        for (int ch = 0; ch < 2; ch++) begin
            commit = m_pend[ch] && (wr[ch] || m_age[ch] == TMO - 1);
            nxt    = press[0] && (int'(m_edit) == ch);
            base   = m_pend[ch] ? m_tgt[ch] : m_sel[ch];
            if (commit) begin
                e.val = m_tgt[ch];
                e.cyc = m_cyc;
                if (ch == 0) q_a.push_back(e);
                else         q_b.push_back(e);
                m_sel[ch] = m_tgt[ch];
            end
            if (nxt) begin
                m_tgt[ch]  = (base + 1) % NW;
                m_pend[ch] = 1;
                m_age[ch]  = 0;
            end else if (commit) begin
                m_pend[ch] = 0;
                m_age[ch]  = 0;
            end else if (m_pend[ch]) begin
                m_age[ch]++;
            end
        end
        if (press[1]) m_edit = !m_edit;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    task automatic mon_ch(input int ch, input logic chg, input logic [2:0] sel);
        exp_t e;
        bit   due;
        if (ch == 0) due = (q_a.size() > 0) && (q_a[0].cyc == m_cyc);
        else         due = (q_b.size() > 0) && (q_b[0].cyc == m_cyc);
        chk(ch == 0 ? "chg_a_pulse" : "chg_b_pulse", int'(chg), int'(due));
        if (due) begin
            if (ch == 0) e = q_a.pop_front();
            else         e = q_b.pop_front();
            chk(ch == 0 ? "sel_a_on_chg" : "sel_b_on_chg", int'(sel), e.val);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                mon_ch(0, chg_a, sel_a);
                mon_ch(1, chg_b, sel_b);
                chk("mon_sel_a",  int'(sel_a),   m_sel[0]);
                chk("mon_sel_b",  int'(sel_b),   m_sel[1]);
                chk("mon_pend_a", int'(pend_a),  int'(m_pend[0]));
                chk("mon_pend_b", int'(pend_b),  int'(m_pend[1]));
                chk("mon_edit",   int'(edit_ch), int'(m_edit));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_next();
        key_next_n = 1'b0; tick(10);
        key_next_n = 1'b1; tick(10);
    endtask

    task automatic press_ch();
        key_ch_n = 1'b0; tick(10);
        key_ch_n = 1'b1; tick(10);
    endtask

    task automatic pulse_wrap_a();
        wrap_a = 1'b1; tick(1); wrap_a = 1'b0;
    endtask

    task automatic pulse_wrap_b();
        wrap_b = 1'b1; tick(1); wrap_b = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sel_a"},  int'(sel_a),   0);
        chk({tag, "_sel_b"},  int'(sel_b),   1);
        chk({tag, "_edit"},   int'(edit_ch), 0);
        chk({tag, "_pend_a"}, int'(pend_a),  0);
        chk({tag, "_pend_b"}, int'(pend_b),  0);
        chk({tag, "_chg_a"},  int'(chg_a),   0);
        chk({tag, "_chg_b"},  int'(chg_b),   0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int n;

        tick(3);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t1");

        // Short bounces must not register.
        key_next_n = 1'b0; tick(2);
        key_next_n = 1'b1; tick(1);
        key_next_n = 1'b0; tick(2);
        key_next_n = 1'b1; tick(10);
        chk("t2_bounce_pend_a", int'(pend_a), 0);
        key_next_n = 1'b0; tick(12);
        chk("t2_press_pend_a", int'(pend_a), 1);
        key_next_n = 1'b1; tick(10);
        pulse_wrap_a();
        chk("t2_sel_a", int'(sel_a), 1);
        chk("t2_chg_a", int'(chg_a), 1);
        chk("t2_pend_a_clr", int'(pend_a), 0);
        tick(2);

        do_reset();
        press_next();
        press_next();
        chk("t3_sel_a_hold", int'(sel_a), 0);
        chk("t3_pend_a", int'(pend_a), 1);
        pulse_wrap_a();
        chk("t3_sel_a_two", int'(sel_a), 2);
        tick(2);
        press_next();
        pulse_wrap_a();
        chk("t3_sel_a_wrap", int'(sel_a), 0);
        tick(2);

        // Timeout commit with no phase wrap.
        key_next_n = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (pend_a) found = 1;
        end
        chk("t4_pend_seen", int'(found), 1);
        key_next_n = 1'b1;
        n = 0;
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            n++;
            if (chg_a) found = 1;
        end
        chk("t4_chg_seen", int'(found), 1);
        chk("t4_timeout_cycles", n, TMO);
        chk("t4_sel_a", int'(sel_a), 1);
        tick(5);

        press_ch();
        chk("t5_edit", int'(edit_ch), 1);
        press_next();
        chk("t5_pend_b", int'(pend_b), 1);
        chk("t5_pend_a", int'(pend_a), 0);
        pulse_wrap_a();
        chk("t5_sel_a_kept", int'(sel_a), 1);
        chk("t5_chg_a_none", int'(chg_a), 0);
        chk("t5_pend_b_kept", int'(pend_b), 1);
        pulse_wrap_b();
        chk("t5_sel_b", int'(sel_b), 2);
        chk("t5_chg_b", int'(chg_b), 1);
        tick(2);

        // Press pulse lands in the same cycle as the phase wrap.
        do_reset();
        press_next();
        key_next_n = 1'b0;
        tick(6);
        wrap_a = 1'b1;
        tick(1);
        wrap_a = 1'b0;
        chk("t6_sel_a", int'(sel_a), 1);
        chk("t6_chg_a", int'(chg_a), 1);
        chk("t6_pend_a_kept", int'(pend_a), 1);
        key_next_n = 1'b1;
        tick(10);
        pulse_wrap_a();
        chk("t6_sel_a_next", int'(sel_a), 2);
        tick(2);
        key_next_n = 1'b0;
        tick(4);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("t6_async");
        key_next_n = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(5, 0) == 0)  key_next_n = ~key_next_n;
            if ($urandom_range(13, 0) == 0) key_ch_n = ~key_ch_n;
            wrap_a = ($urandom_range(39, 0) == 0);
            wrap_b = ($urandom_range(39, 0) == 0);
        end
        key_next_n = 1'b1;
        key_ch_n   = 1'b1;
        wrap_a     = 1'b0;
        wrap_b     = 1'b0;
        tick(80);
        chk("end_q_a_empty", q_a.size(), 0);
        chk("end_q_b_empty", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
